mc_datapath: RTL and testbench
==============================

Name: mc_datapath

Overview:
- Multicycle CPU datapath: the consumer end of the multicycle controller's control bus.
- Holds PC, IR, register file, A/B/ALUOut/MDR latches and ALU. Executes the control word issued each cycle.
- Returns op, func and z to the controller. Drives external instruction and data memory address/data buses; memory write enable is driven by the controller directly.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NREG_LOG2, 5, register file address width (2**NREG_LOG2 registers, 32 bits each)

Ports:
clock  in  1  system clock, all state updates on rising edge
resetn  in  1  synchronous, active-low reset
wpc  in  1  PC write enable
wir  in  1  IR write enable
wreg  in  1  register file write enable
regrt  in  2  dest select: 0=r31, 1=rt IR[20:16], 2=rd IR[15:11], 3=no write
m2reg  in  1  WB source when wrRegData=1: 0=ALUOut, 1=MDR
wrRegData  in  1  write data select: 0=PC+4 (link), 1=m2reg mux
aluc  in  3  ALU op
alusrcb  in  1  ALU B operand: 0=B latch, 1=extended imm
pcsource  in  2  next PC: 0=PC+4, 1=branch target, 2=rs read data, 3=jump target
sext  in  1  imm extension: 1=sign, 0=zero
imem_rdata  in  32  instruction word at imem_addr
dmem_rdata  in  32  data word at dmem_addr
op  out  6  IR[31:26]
func  out  6  IR[5:0]
z  out  1  combinational: ALU result == 0
imem_addr  out  32  = PC
dmem_addr  out  32  = ALUOut latch
dmem_wdata  out  32  = B latch
pc  out  32  current PC (observation)

Behaviour:
- Reset (resetn=0 at edge): PC=RESET_PC; IR, A, B, ALUOut, MDR = 0; all registers = 0. op=0, func=0 after reset.
- PC holds the current instruction address for the instruction's whole life. PC+4 is combinational from PC.
- IR <= imem_rdata when wir=1, else hold.
- A <= regfile[IR[25:21]], B <= regfile[IR[20:16]], ALUOut <= ALU result, MDR <= dmem_rdata — unconditionally every cycle.
- Register file: two combinational read ports; one synchronous write port. r0 always reads 0 and writes to it are dropped. Write occurs when wreg=1 and regrt!=3.
- Same-cycle write/read of the same register returns the old value; the new value is visible next cycle.
- Imm: sext ? {{16{IR[15]}},IR[15:0]} : {16'b0,IR[15:0]}.
- ALU operands: opA = A, opB = alusrcb ? imm : B.
- ALU ops:
  - 000 add
  - 001 sub
  - 010 signed slt, result 1/0
  - 100 sll: B << IR[10:6]; B latch always, alusrcb ignored
  - 101 or
  - 110 and
  - 011 and 111 produce 0
- Arithmetic wraps mod 2^32; no overflow flag.
- Next PC, loaded when wpc=1, else PC holds:
  - pcsource 0: PC+4
  - pcsource 1: PC+4 + (sign-ext imm << 2); sign extension forced regardless of sext
  - pcsource 2: regfile[IR[25:21]] read port, not the A latch, so jr completes in ID
  - pcsource 3: {PC+4[31:28], IR[25:0], 2'b00}
- z reflects the same-cycle ALU result. The controller samples it in EXE for beq.
- Simultaneous wpc and wreg with wrRegData=0 (jal): link value uses the pre-update PC+4.
- Simultaneous wir and wpc: both take effect; IR gets the word at the old PC.
- Reset mid-instruction: all state reinitialised on that edge; pending writes discarded.

Optional Feature:
- Macro MC_DATAPATH_DBG_EN.
- When defined: adds input dbg_raddr [NREG_LOG2-1:0] and output dbg_rdata [31:0], a third combinational read port for bench/board inspection.
- dbg_raddr=0 returns 0. Same old-value semantics as the main read ports.
- When undefined: ports absent; no extra logic.

Test Plan:
- Reset: hold resetn=0 two cycles, RESET_PC=0 -> pc=0, op=0, func=0, every register reads 0 via dbg port.
- addi/add: IR=addi r1,r0,5, then WB (regrt=1, wrRegData=1, m2reg=0, wreg=1) -> r1=5. add r3,r1,r1 with aluc=000, alusrcb=0 -> r3=10, z=0.
- Edges: sub r1,r1 -> z=1. slt with A=32'hFFFF_FFFF, B=1 -> 1. sll with B=1, sa=31 -> 32'h8000_0000. ori with imm 16'h8000, sext=0 -> 32'h0000_8000.
- lw/sw: sw r3,8(r0) -> dmem_addr=8, dmem_wdata=10 in MEM. lw r4,8(r0) with dmem_rdata=10 -> r4=10 after WB.
- Branches, PC=0x40:
  - beq taken, imm=-1 -> PC=0x40.
  - beq not taken -> PC=0x44.
  - j 0x100 -> PC=0x400.
  - jal -> r31=0x44.
  - jr r31 -> PC=0x44.
- r0 write: WB with regrt=2, rd=0, value 7 -> r0 still reads 0. regrt=3 with wreg=1 -> no register changes.

Source files
------------

// File: rtl/mc_datapath.sv
// mc_datapath -- multicycle CPU datapath, the consumer of the controller's
// control bus. Holds PC, IR, register file, A/B/ALUOut/MDR latches and ALU,
// and executes whatever control word is presented each cycle.
//
// Ports
//   clock, resetn        rising-edge clock, synchronous active-low reset
//   wpc, wir, wreg       PC / IR / register-file write enables
//   regrt[1:0]           dest: 0=r31, 1=rt, 2=rd, 3=no write
//   m2reg, wrRegData     write-back source select (PC+4 / ALUOut / MDR)
//   aluc[2:0], alusrcb   ALU op and B-operand select
//   pcsource[1:0]        next PC: PC+4 / branch / rs / jump
//   sext                 immediate extension (1=sign, 0=zero)
//   imem_rdata,dmem_rdata memory read data
//   op, func, z          decode fields and zero flag back to the controller
//   imem_addr, dmem_addr, dmem_wdata, pc   memory buses and PC observation
//
// Optional build macro MC_DATAPATH_DBG_EN adds a third combinational read
// port (dbg_raddr / dbg_rdata) for register inspection.

module mc_datapath #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          NREG_LOG2 = 5
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 wpc,
   input  logic                 wir,
   input  logic                 wreg,
   input  logic [1:0]           regrt,
   input  logic                 m2reg,
   input  logic                 wrRegData,
   input  logic [2:0]           aluc,
   input  logic                 alusrcb,
   input  logic [1:0]           pcsource,
   input  logic                 sext,
   input  logic [31:0]          imem_rdata,
   input  logic [31:0]          dmem_rdata,
`ifdef MC_DATAPATH_DBG_EN
   input  logic [NREG_LOG2-1:0] dbg_raddr,
   output logic [31:0]          dbg_rdata,
`endif
   output logic [5:0]           op,
   output logic [5:0]           func,
   output logic                 z,
   output logic [31:0]          imem_addr,
   output logic [31:0]          dmem_addr,
   output logic [31:0]          dmem_wdata,
   output logic [31:0]          pc
);

   localparam int NREG = 1 << NREG_LOG2;

   logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, mdr_q;
   logic [31:0] rf_q [0:NREG-1];

   logic [NREG_LOG2-1:0] rs_addr, rt_addr, rd_addr, wr_addr;
   logic [31:0]          rs_data, rt_data;
   logic [31:0]          imm, opb, alu_r;
   logic [31:0]          pc_plus4, br_off, pc_d, wr_data;
   logic                 wr_en;

   assign rs_addr = ir_q[21 +: NREG_LOG2];
   assign rt_addr = ir_q[16 +: NREG_LOG2];
   assign rd_addr = ir_q[11 +: NREG_LOG2];

   // Read ports return the stored value, so a same-cycle write is only
   // visible on the following cycle.
   assign rs_data = (rs_addr == '0) ? 32'h0 : rf_q[rs_addr];
   assign rt_data = (rt_addr == '0) ? 32'h0 : rf_q[rt_addr];

`ifdef MC_DATAPATH_DBG_EN
   assign dbg_rdata = (dbg_raddr == '0) ? 32'h0 : rf_q[dbg_raddr];
`endif

   assign imm = sext ? {{16{ir_q[15]}}, ir_q[15:0]} : {16'h0, ir_q[15:0]};
   assign opb = alusrcb ? imm : b_q;

   always_comb begin
      alu_r = 32'h0;
      case (aluc)
         3'b000:  alu_r = a_q + opb;
         3'b001:  alu_r = a_q - opb;
         3'b010:  alu_r = {31'h0, $signed(a_q) < $signed(opb)};
         3'b100:  alu_r = b_q << ir_q[10:6];   // shifts always use the B latch
         3'b101:  alu_r = a_q | opb;
         3'b110:  alu_r = a_q & opb;
         default: alu_r = 32'h0;
      endcase
   end

   assign z = (alu_r == 32'h0);

   // Branch offset is always sign-extended, independent of sext.
   assign pc_plus4 = pc_q + 32'd4;
   assign br_off   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

   always_comb begin
      pc_d = pc_plus4;
      case (pcsource)
         2'd0: pc_d = pc_plus4;
         2'd1: pc_d = pc_plus4 + br_off;
         2'd2: pc_d = rs_data;               // read port, so jr resolves in ID
         2'd3: pc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
      endcase
   end

   always_comb begin
      wr_addr = '0;
      case (regrt)
         2'd0:    wr_addr = '1;
         2'd1:    wr_addr = rt_addr;
         2'd2:    wr_addr = rd_addr;
         default: wr_addr = '0;
      endcase
   end

   // Link value comes from the pre-update PC, so jal can write PC and r31
   // in the same cycle.
   assign wr_data = wrRegData ? (m2reg ? mdr_q : aluout_q) : pc_plus4;
   assign wr_en   = wreg && (regrt != 2'd3) && (wr_addr != '0);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         pc_q     <= RESET_PC;
         ir_q     <= 32'h0;
         a_q      <= 32'h0;
         b_q      <= 32'h0;
         aluout_q <= 32'h0;
         mdr_q    <= 32'h0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= 32'h0;
      end else begin
         if (wpc) pc_q <= pc_d;
         if (wir) ir_q <= imem_rdata;
         a_q      <= rs_data;
         b_q      <= rt_data;
         aluout_q <= alu_r;
         mdr_q    <= dmem_rdata;
         if (wr_en) rf_q[wr_addr] <= wr_data;
      end
   end

   assign op         = ir_q[31:26];
   assign func       = ir_q[5:0];
   assign imem_addr  = pc_q;
   assign dmem_addr  = aluout_q;
   assign dmem_wdata = b_q;
   assign pc         = pc_q;

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

   logic        clock = 1'b0;
   logic        resetn;
   logic        wpc, wir, wreg, m2reg, wrRegData, alusrcb, sext;
   logic [1:0]  regrt, pcsource;
   logic [2:0]  aluc;
   logic [31:0] imem_rdata, dmem_rdata;
   logic [5:0]  op, func;
   logic        z;
   logic [31:0] imem_addr, dmem_addr, dmem_wdata, pc;
`ifdef MC_DATAPATH_DBG_EN
   logic [4:0]  dbg_raddr;
   logic [31:0] dbg_rdata;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   mc_datapath #(.RESET_PC(32'h0000_0000), .NREG_LOG2(5)) dut (
      .clock(clock), .resetn(resetn),
      .wpc(wpc), .wir(wir), .wreg(wreg), .regrt(regrt),
      .m2reg(m2reg), .wrRegData(wrRegData), .aluc(aluc),
      .alusrcb(alusrcb), .pcsource(pcsource), .sext(sext),
      .imem_rdata(imem_rdata), .dmem_rdata(dmem_rdata),
`ifdef MC_DATAPATH_DBG_EN
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
`endif
      .op(op), .func(func), .z(z),
      .imem_addr(imem_addr), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .pc(pc)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [2:0]  aluc;
      logic        srcb;
      logic        sx;
      logic [31:0] exp_r;
      logic        exp_z;
   } vec_t;

   vec_t vecs [13];

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sa, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] im);
      return {opc, rs, rt, im};
   endfunction

   function automatic logic [31:0] jtype(input logic [5:0] opc, input logic [25:0] t);
      return {opc, t};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic load_ir(input logic [31:0] w);
      imem_rdata = w;
      wir = 1'b1;
      tick;
      wir = 1'b0;
   endtask

   // Load instruction, latch A/B, present ALU control, sample z, latch ALUOut.
   task automatic exec(input logic [31:0] w, input logic [2:0] a_op,
                       input logic srcb, input logic sx, output logic z_o);
      load_ir(w);
      tick;
      aluc = a_op;
      alusrcb = srcb;
      sext = sx;
      #1;
      z_o = z;
      tick;
   endtask

   task automatic wb(input logic [1:0] rr, input logic m2, input logic wrd);
      regrt = rr;
      m2reg = m2;
      wrRegData = wrd;
      wreg = 1'b1;
      tick;
      wreg = 1'b0;
      regrt = 2'd3;
   endtask

   task automatic set_pc(input logic [1:0] ps);
      pcsource = ps;
      wpc = 1'b1;
      tick;
      wpc = 1'b0;
   endtask

   // Register contents observed through the B latch (dmem_wdata).
   task automatic read_reg(input int n, output logic [31:0] v);
      load_ir(rtype(5'd0, n[4:0], 5'd0, 5'd0, 6'd0));
      tick;
      v = dmem_wdata;
`ifdef MC_DATAPATH_DBG_EN
      dbg_raddr = n[4:0];
      #1;
      check("dbg_rdata", dbg_rdata, v);
`endif
   endtask

   logic [31:0] v;
   logic        zz;

   initial begin
      vecs[0]  = '{"add",      rtype(1,1,9,0,6'h20),      3'd0, 1'b0, 1'b1, 32'd10,        1'b0};
      vecs[1]  = '{"sub_zero", rtype(1,1,9,0,6'h22),      3'd1, 1'b0, 1'b1, 32'd0,         1'b1};
      vecs[2]  = '{"slt_neg",  rtype(2,5,9,0,6'h2a),      3'd2, 1'b0, 1'b1, 32'd1,         1'b0};
      vecs[3]  = '{"slt_pos",  rtype(5,2,9,0,6'h2a),      3'd2, 1'b0, 1'b1, 32'd0,         1'b1};
      vecs[4]  = '{"sll31",    rtype(0,5,9,31,6'h00),     3'd4, 1'b1, 1'b1, 32'h8000_0000, 1'b0};
      vecs[5]  = '{"ori_zext", itype(6'h0d,0,9,16'h8000), 3'd5, 1'b1, 1'b0, 32'h0000_8000, 1'b0};
      vecs[6]  = '{"addi_sx",  itype(6'h08,0,9,16'h8000), 3'd0, 1'b1, 1'b1, 32'hFFFF_8000, 1'b0};
      vecs[7]  = '{"and",      rtype(2,3,9,0,6'h24),      3'd6, 1'b0, 1'b1, 32'd10,        1'b0};
      vecs[8]  = '{"or",       rtype(1,3,9,0,6'h25),      3'd5, 1'b0, 1'b1, 32'd15,        1'b0};
      vecs[9]  = '{"sub_neg",  rtype(5,2,9,0,6'h22),      3'd1, 1'b0, 1'b1, 32'd2,         1'b0};
      vecs[10] = '{"aluc3",    rtype(1,3,9,0,6'h20),      3'd3, 1'b0, 1'b1, 32'd0,         1'b1};
      vecs[11] = '{"aluc7",    rtype(1,3,9,0,6'h20),      3'd7, 1'b0, 1'b1, 32'd0,         1'b1};
      vecs[12] = '{"add_wrap", rtype(2,5,9,0,6'h20),      3'd0, 1'b0, 1'b1, 32'd0,         1'b1};

      resetn = 1'b0; wpc = 0; wir = 0; wreg = 0; m2reg = 0; wrRegData = 0;
      alusrcb = 0; sext = 0; regrt = 2'd3; pcsource = 0; aluc = 0;
      imem_rdata = 32'h0; dmem_rdata = 32'h0;
`ifdef MC_DATAPATH_DBG_EN
      dbg_raddr = 5'd0;
`endif
      tick;
      tick;
      check("rst_pc", pc, 32'h0);
      check("rst_op", {26'h0, op}, 32'h0);
      check("rst_func", {26'h0, func}, 32'h0);
      check("rst_dmem_addr", dmem_addr, 32'h0);
      check("rst_dmem_wdata", dmem_wdata, 32'h0);
      resetn = 1'b1;
      for (int i = 0; i < 32; i++) begin
         read_reg(i, v);
         check($sformatf("rst_r%0d", i), v, 32'h0);
      end

      // r1=5, r2=-1, r5=1 via addi; r3 = r1+r1
      exec(itype(6'h08,0,1,16'd5), 3'd0, 1'b1, 1'b1, zz);
      check("addi_aluout", dmem_addr, 32'd5);
      wb(2'd1, 1'b0, 1'b1);
      exec(itype(6'h08,0,2,16'hFFFF), 3'd0, 1'b1, 1'b1, zz); wb(2'd1, 1'b0, 1'b1);
      exec(itype(6'h08,0,5,16'd1),    3'd0, 1'b1, 1'b1, zz); wb(2'd1, 1'b0, 1'b1);
      read_reg(1, v); check("r1", v, 32'd5);
      exec(rtype(1,1,3,0,6'h20), 3'd0, 1'b0, 1'b1, zz);
      check("add_z", {31'h0, zz}, 32'd0);
      check("add_func", {26'h0, func}, 32'h20);
      wb(2'd2, 1'b0, 1'b1);
      read_reg(3, v); check("r3", v, 32'd10);
      read_reg(2, v); check("r2", v, 32'hFFFF_FFFF);

      foreach (vecs[k]) begin
         exec(vecs[k].instr, vecs[k].aluc, vecs[k].srcb, vecs[k].sx, zz);
         check({vecs[k].name, "_z"}, {31'h0, zz}, {31'h0, vecs[k].exp_z});
         check({vecs[k].name, "_res"}, dmem_addr, vecs[k].exp_r);
      end

      // sw r3,8(r0) / lw r4,8(r0)
      exec(itype(6'h2b,0,3,16'd8), 3'd0, 1'b1, 1'b1, zz);
      check("sw_addr", dmem_addr, 32'd8);
      check("sw_wdata", dmem_wdata, 32'd10);
      exec(itype(6'h23,0,4,16'd8), 3'd0, 1'b1, 1'b1, zz);
      check("lw_op", {26'h0, op}, 32'h23);
      dmem_rdata = 32'd10;
      tick;
      wb(2'd1, 1'b1, 1'b1);
      dmem_rdata = 32'h0;
      read_reg(4, v); check("lw_r4", v, 32'd10);

      // Branches and jumps around PC=0x40
      load_ir(jtype(6'h02, 26'h10)); set_pc(2'd3);
      check("j_0x40", pc, 32'h40);
      load_ir(itype(6'h04,1,1,16'hFFFF)); sext = 1'b0; set_pc(2'd1);
      check("beq_taken", pc, 32'h40);
      set_pc(2'd0);
      check("beq_not_taken", pc, 32'h44);
      load_ir(itype(6'h04,1,1,16'hFFFE)); set_pc(2'd1);
      check("beq_back", pc, 32'h40);
      load_ir(jtype(6'h02, 26'h100)); set_pc(2'd3);
      check("j_0x100", pc, 32'h400);
      load_ir(jtype(6'h02, 26'h10)); set_pc(2'd3);
      load_ir(jtype(6'h03, 26'h100));
      pcsource = 2'd3; wpc = 1'b1; wreg = 1'b1; regrt = 2'd0; wrRegData = 1'b0;
      tick;
      wpc = 1'b0; wreg = 1'b0; regrt = 2'd3; wrRegData = 1'b1;
      check("jal_pc", pc, 32'h400);
      load_ir(rtype(31,0,0,0,6'h08)); set_pc(2'd2);
      check("jr_pc", pc, 32'h44);
      read_reg(31, v); check("jal_r31", v, 32'h44);

      // wir and wpc together
      imem_rdata = itype(6'h0d,0,0,16'h0);
      wir = 1'b1; wpc = 1'b1; pcsource = 2'd0;
      tick;
      wir = 1'b0; wpc = 1'b0;
      check("wir_wpc_pc", pc, 32'h48);
      check("wir_wpc_op", {26'h0, op}, 32'h0d);
      check("imem_addr", imem_addr, 32'h48);

      // r0 write dropped; regrt=3 writes nothing
      exec(itype(6'h08,0,0,16'd7), 3'd0, 1'b1, 1'b1, zz);
      check("r0_val", dmem_addr, 32'd7);
      wb(2'd2, 1'b0, 1'b1);
      read_reg(0, v); check("r0_zero", v, 32'h0);
      exec(itype(6'h08,0,6,16'd9), 3'd0, 1'b1, 1'b1, zz);
      wb(2'd3, 1'b0, 1'b1);
      read_reg(6, v); check("regrt3_r6", v, 32'h0);
      read_reg(1, v); check("regrt3_r1", v, 32'd5);

      // Same-cycle write/read: B latches old r7 on the write edge
      exec(itype(6'h08,7,7,16'd3), 3'd0, 1'b1, 1'b1, zz);
      wb(2'd1, 1'b0, 1'b1);
      check("wr_rd_old", dmem_wdata, 32'h0);
      tick;
      check("wr_rd_new", dmem_wdata, 32'd3);

      // Reset mid-instruction with a pending write
      exec(itype(6'h08,0,8,16'h55), 3'd0, 1'b1, 1'b1, zz);
      regrt = 2'd1; wreg = 1'b1; wrRegData = 1'b1; m2reg = 1'b0;
      resetn = 1'b0;
      tick;
      resetn = 1'b1; wreg = 1'b0; regrt = 2'd3;
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_op", {26'h0, op}, 32'h0);
      check("mid_rst_aluout", dmem_addr, 32'h0);
      read_reg(8, v); check("mid_rst_r8", v, 32'h0);
      read_reg(1, v); check("mid_rst_r1", v, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
